key_debounce: RTL and testbench

Per-key debouncer that sits directly upstream of the LED control stage. It takes raw active-low push-button inputs and drives the debounced key bus that the LED stage decodes. Each key is synchronised, filtered with an independent stable-time counter, and reported as:
- a clean active-low level;
- one-cycle press, release and long-hold event pulses for later control logic.

---
 rtl/key_debounce.sv | 137 +++++++++++++
 tb/tb_key_debounce.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/key_debounce.sv
// Per-key push-button debouncer: two-flop synchroniser, then an independent
// stable-time filter per key. Each key reports a clean level and one-cycle press/release/hold pulses.
module key_debounce #(
  parameter int WIDTH        = 2,
  parameter int DEBOUNCE_CYC = 1000000,
  parameter int HOLD_CYC     = 50000000
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic [WIDTH-1:0] key_in,
  output logic [WIDTH-1:0] key_value,
  output logic [WIDTH-1:0] key_press,
  output logic [WIDTH-1:0] key_release,
  output logic [WIDTH-1:0] key_hold
);

  localparam int MAX_CYC = (DEBOUNCE_CYC > HOLD_CYC) ? DEBOUNCE_CYC : HOLD_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_SAT  = CNT_W'(HOLD_CYC);

  typedef enum logic [1:0] {
    REL,
    F_DN,
    PRS,
    F_UP
  } state_t;

  // Parks at HOLD_CYC, so the HOLD_LAST match (and the hold pulse) happens once per press.
  function automatic logic [CNT_W-1:0] hold_sat_inc(input logic [CNT_W-1:0] v);
    return (v == HOLD_SAT) ? v : v + CNT_ONE;
  endfunction

  logic [WIDTH-1:0] sync_p0;
  logic [WIDTH-1:0] sync_p1;

  // Stage p0/p1: metastability synchroniser; idle level is released (1).
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync_p0 <= '1;
      sync_p1 <= '1;
    end else begin
      sync_p0 <= key_in;
      sync_p1 <= sync_p0;
    end
  end

  for (genvar k = 0; k < WIDTH; k++) begin : g_key
    state_t           state;
    logic [CNT_W-1:0] stable_cnt;
    logic [CNT_W-1:0] hold_cnt;
    logic             value_r;
    logic             press_r;
    logic             rel_r;
    logic             hold_r;
    logic             s;

    assign s = sync_p1[k];

    // Filter FSM: outputs registered alongside state.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        state      <= REL;
        stable_cnt <= '0;
        hold_cnt   <= '0;
        value_r    <= 1'b1;
        press_r    <= 1'b0;
        rel_r      <= 1'b0;
        hold_r     <= 1'b0;
      end else begin
        press_r <= 1'b0;
        rel_r   <= 1'b0;
        hold_r  <= 1'b0;
        case (state)
          REL: begin
            if (!s) begin
              state      <= F_DN;
              stable_cnt <= CNT_ONE;
            end
          end
          F_DN: begin
            if (s) begin
              state      <= REL;
              stable_cnt <= '0;
            end else if (stable_cnt == DB_LAST) begin
              state      <= PRS;
              stable_cnt <= '0;
              hold_cnt   <= '0;
              value_r    <= 1'b0;
              press_r    <= 1'b1;
            end else begin
              stable_cnt <= stable_cnt + CNT_ONE;
            end
          end
          PRS: begin
            if (hold_cnt == HOLD_LAST) hold_r <= 1'b1;
            hold_cnt <= hold_sat_inc(hold_cnt);
            if (s) begin
              state      <= F_UP;
              stable_cnt <= CNT_ONE;
            end
          end
          F_UP: begin
            // hold_cnt frozen here so a bounce back to PRS cannot re-arm the hold pulse.
            if (!s) begin
              state      <= PRS;
              stable_cnt <= '0;
            end else if (stable_cnt == DB_LAST) begin
              state      <= REL;
              stable_cnt <= '0;
              hold_cnt   <= '0;
              value_r    <= 1'b1;
              rel_r      <= 1'b1;
            end else begin
              stable_cnt <= stable_cnt + CNT_ONE;
            end
          end
          default: begin
            state      <= REL;
            stable_cnt <= '0;
            hold_cnt   <= '0;
            value_r    <= 1'b1;
          end
        endcase
      end
    end

    assign key_value[k]   = value_r;
    assign key_press[k]   = press_r;
    assign key_release[k] = rel_r;
    assign key_hold[k]    = hold_r;
  end

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with short filter/hold times (DEBOUNCE_CYC=4, HOLD_CYC=10).
module tb_key_debounce;
  localparam int WIDTH        = 2;
  localparam int DEBOUNCE_CYC = 4;
  localparam int HOLD_CYC     = 10;

  logic             sys_clk = 1'b0;
  logic             sys_rst_n;
  logic [WIDTH-1:0] key_in;
  logic [WIDTH-1:0] key_value;
  logic [WIDTH-1:0] key_press;
  logic [WIDTH-1:0] key_release;
  logic [WIDTH-1:0] key_hold;

  int checks   = 0;
  int failures = 0;
  int press_n[WIDTH];
  int rel_n[WIDTH];
  int hold_n[WIDTH];
  logic [WIDTH-1:0] low_seen;
  int hold_edge;
  logic glitch_up;

  always #5 sys_clk = ~sys_clk;

  key_debounce #(
    .WIDTH(WIDTH),
    .DEBOUNCE_CYC(DEBOUNCE_CYC),
    .HOLD_CYC(HOLD_CYC)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst_n(sys_rst_n),
    .key_in(key_in),
    .key_value(key_value),
    .key_press(key_press),
    .key_release(key_release),
    .key_hold(key_hold)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    for (int i = 0; i < WIDTH; i++) begin
      press_n[i] = 0;
      rel_n[i]   = 0;
      hold_n[i]  = 0;
    end
    low_seen = '0;
  endtask

  // One active edge, then sample 1 ns later and accumulate pulse counts.
  task automatic tick();
    @(posedge sys_clk);
    #1;
    for (int i = 0; i < WIDTH; i++) begin
      if (key_press[i])   press_n[i]++;
      if (key_release[i]) rel_n[i]++;
      if (key_hold[i])    hold_n[i]++;
    end
    low_seen |= ~key_value;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  initial begin
    sys_rst_n = 1'b0;
    key_in    = 2'b11;
    clear_counts();
    run(3);
    chk("rst_value", 32'(key_value), 32'h3);
    chk("rst_press", 32'(key_press), 32'h0);
    chk("rst_release", 32'(key_release), 32'h0);
    chk("rst_hold", 32'(key_hold), 32'h0);
    sys_rst_n = 1'b1;

    // Idle after reset release
    clear_counts();
    run(50);
    chk("idle_low_seen", 32'(low_seen), 32'h0);
    chk("idle_pulses", 32'(press_n[0] + press_n[1] + rel_n[0] + rel_n[1] + hold_n[0] + hold_n[1]), 32'h0);

    // Key 0 press: accepted at edge 5
    clear_counts();
    key_in = 2'b10;
    run(5);
    chk("k0_value_e4", 32'(key_value), 32'h3);
    chk("k0_press_e4", 32'(key_press), 32'h0);
    tick();
    chk("k0_value_e5", 32'(key_value), 32'h2);
    chk("k0_press_e5", 32'(key_press), 32'h1);
    tick();
    chk("k0_press_e6", 32'(key_press), 32'h0);
    run(5);
    chk("k0_press_count", 32'(press_n[0]), 32'h1);
    chk("k1_untouched", 32'(low_seen[1]), 32'h0);

    // Key 0 release: accepted at edge 5
    key_in = 2'b11;
    run(5);
    chk("k0_rel_value_e4", 32'(key_value), 32'h2);
    tick();
    chk("k0_rel_value_e5", 32'(key_value), 32'h3);
    chk("k0_rel_pulse_e5", 32'(key_release), 32'h1);
    tick();
    chk("k0_rel_pulse_e6", 32'(key_release), 32'h0);
    run(5);

    // Bounce on key 0 never completes the filter
    clear_counts();
    key_in = 2'b10; run(2);
    key_in = 2'b11; run(1);
    key_in = 2'b10; run(2);
    key_in = 2'b11; run(10);
    chk("bounce_low_seen", 32'(low_seen), 32'h0);
    chk("bounce_press", 32'(press_n[0]), 32'h0);
    chk("bounce_release", 32'(rel_n[0]), 32'h0);

    // Key 1 long press: hold fires 10 cycles after key_value fall
    clear_counts();
    key_in = 2'b01;
    for (int e = 0; e < 20; e++) begin
      tick();
      if (e == 4) chk("k1_value_e4", 32'(key_value), 32'h3);
      if (e == 5) begin
        chk("k1_value_e5", 32'(key_value), 32'h1);
        chk("k1_press_e5", 32'(key_press), 32'h2);
      end
      if (e == 14) chk("k1_hold_e14", 32'(key_hold), 32'h0);
      if (e == 15) chk("k1_hold_e15", 32'(key_hold), 32'h2);
      if (e == 16) chk("k1_hold_e16", 32'(key_hold), 32'h0);
    end
    chk("k1_press_count", 32'(press_n[1]), 32'h1);
    chk("k1_hold_count", 32'(hold_n[1]), 32'h1);
    key_in = 2'b11;
    run(5);
    chk("k1_rel_value_e4", 32'(key_value), 32'h1);
    tick();
    chk("k1_rel_value_e5", 32'(key_value), 32'h3);
    chk("k1_rel_pulse_e5", 32'(key_release), 32'h2);
    run(5);
    chk("k1_rel_count", 32'(rel_n[1]), 32'h1);
    chk("k1_hold_no_repeat", 32'(hold_n[1]), 32'h1);

    // Key 1 held with a 2-cycle high glitch
    clear_counts();
    glitch_up = 1'b0;
    hold_edge = -1;
    key_in = 2'b01;
    for (int e = 0; e <= 30; e++) begin
      tick();
      if (e >= 5 && key_value[1]) glitch_up = 1'b1;
      if (key_hold[1]) hold_edge = e;
      if (e == 8)  key_in = 2'b11;
      if (e == 10) key_in = 2'b01;
    end
    chk("glitch_value_up", 32'(glitch_up), 32'h0);
    chk("glitch_release", 32'(rel_n[1]), 32'h0);
    chk("glitch_hold_count", 32'(hold_n[1]), 32'h1);
    chk("glitch_hold_edge", 32'(hold_edge), 32'd17);
    key_in = 2'b11;
    run(12);
    chk("glitch_final_release", 32'(rel_n[1]), 32'h1);
    chk("glitch_final_hold", 32'(hold_n[1]), 32'h1);

    // Reset mid-operation: key 0 in F_DN, key 1 in PRS
    key_in = 2'b01;
    run(7);
    key_in = 2'b00;
    run(3);
    chk("mid_pre_value", 32'(key_value), 32'h1);
    #2 sys_rst_n = 1'b0;
    #1;
    chk("mid_rst_value", 32'(key_value), 32'h3);
    chk("mid_rst_pulses", 32'({key_press, key_release, key_hold}), 32'h0);
    run(2);
    sys_rst_n = 1'b1;
    clear_counts();
    for (int e = 0; e < 7; e++) begin
      tick();
      if (e == 4) begin
        chk("restart_value_e4", 32'(key_value), 32'h3);
        chk("restart_press_e4", 32'(key_press), 32'h0);
      end
      if (e == 5) begin
        chk("restart_value_e5", 32'(key_value), 32'h0);
        chk("restart_press_e5", 32'(key_press), 32'h3);
      end
      if (e == 6) chk("restart_press_e6", 32'(key_press), 32'h0);
    end
    key_in = 2'b11;
    run(10);
    chk("restart_release_both", 32'(rel_n[0] + rel_n[1]), 32'h2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
